pipeline_controller: RTL

Central stall/flush sequencer for the 5-stage in-order core, built around the execute stage. It consumes execute-stage resolution signals (taken branch, final instruction, load in flight) plus decode source-register usage and memory busy. It drives per-stage stall, flush and bubble controls, the fetch redirect, and the halt indication. It also keeps saturating stall/flush performance counters.

---
 rtl/pipeline_controller.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage in-order core.
// Stage controls are combinational from the current state and this cycle's
// inputs. The sequencing state, the down-counter and the perf counters are registered.
module pipeline_controller #(
  parameter int unsigned LOAD_USE_BUBBLES = 1,
  parameter int unsigned FLUSH_CYCLES     = 2,
  parameter int unsigned CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs1,
  input  logic             id_rs1_used,
  input  logic [4:0]       id_rs2,
  input  logic             id_rs2_used,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic             ex_write_to_rd,
  input  logic             ex_is_load,
  input  logic             ex_branch_taken,
  input  logic [63:0]      ex_branch_target,
  input  logic             ex_is_final,
  input  logic             mem_busy,
  input  logic             wb_final_retired,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             stall_execute,
  output logic             flush_fetch,
  output logic             flush_decode,
  output logic             bubble_execute,
  output logic             redirect_valid,
  output logic [63:0]      redirect_pc,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cycle_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [2:0] {
    S_RUN,
    S_FLUSH,
    S_LOAD_USE,
    S_DRAIN,
    S_HALTED
  } state_t;

  // The counter holds the cycles still to spend in FLUSH/LOAD_USE, including the current one.
  localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);
  localparam logic [3:0] LU_INIT    = 4'(LOAD_USE_BUBBLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       hazard, branch_ev, final_ev, freeze, flush_ev;

  assign branch_ev = ex_valid & ex_branch_taken;
  assign final_ev  = ex_valid & ex_is_final;
  assign hazard    = id_valid & ex_valid & ex_is_load & ex_write_to_rd & (ex_rd != 5'd0) &
                     ((id_rs1_used & (id_rs1 == ex_rd)) | (id_rs2_used & (id_rs2 == ex_rd)));
  // A halted core ignores memory. Everywhere else, a busy memory freezes the whole pipe.
  assign freeze    = mem_busy & (state_q != S_HALTED);

  // Next-state and Mealy stage controls; reset forces every control low.
  always_comb begin
    // NOTE: every output gets a default first, so no path through the case infers a latch.
    state_d        = state_q;
    cnt_d          = cnt_q;
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    stall_execute  = 1'b0;
    flush_fetch    = 1'b0;
    flush_decode   = 1'b0;
    bubble_execute = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    halted         = 1'b0;
    flush_ev       = 1'b0;
    if (rst) begin
      state_d = S_RUN;
    end else if (freeze) begin
      // Execute is held, so branch/final/hazard stay pending until memory frees up.
      stall_fetch   = 1'b1;
      stall_decode  = 1'b1;
      stall_execute = 1'b1;
    end else begin
      unique case (state_q)
        S_RUN: begin
          if (branch_ev) begin
            redirect_valid = 1'b1;
            redirect_pc    = ex_branch_target;
            flush_fetch    = 1'b1;
            flush_decode   = 1'b1;
            flush_ev       = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d = S_FLUSH;
              cnt_d   = FLUSH_INIT;
            end
          end else if (final_ev) begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
            stall_fetch  = 1'b1;
            state_d      = S_DRAIN;
          end else if (hazard) begin
            stall_fetch    = 1'b1;
            stall_decode   = 1'b1;
            bubble_execute = 1'b1;
            if (LOAD_USE_BUBBLES > 1) begin
              state_d = S_LOAD_USE;
              cnt_d   = LU_INIT;
            end
          end
        end
        S_FLUSH: begin
          flush_fetch  = 1'b1;
          flush_decode = 1'b1;
          cnt_d        = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_RUN;
        end
        S_LOAD_USE: begin
          stall_fetch    = 1'b1;
          stall_decode   = 1'b1;
          bubble_execute = 1'b1;
          cnt_d          = cnt_q - 4'd1;
          if (cnt_q <= 4'd1) state_d = S_RUN;
        end
        S_DRAIN: begin
          stall_fetch  = 1'b1;
          flush_decode = 1'b1;
          if (wb_final_retired) state_d = S_HALTED;
        end
        S_HALTED: begin
          halted       = 1'b1;
          stall_fetch  = 1'b1;
          flush_decode = 1'b1;
        end
        default: state_d = S_RUN;
      endcase
    end
  end

  // State and down-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so that every register samples pre-edge values.
    if (rst) begin
      state_q <= S_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Saturating performance counters; halted cycles do not count as stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycle_count <= '0;
      flush_count       <= '0;
    end else begin
      if (stall_fetch && (state_q != S_HALTED) && (stall_cycle_count != '1))
        stall_cycle_count <= stall_cycle_count + CNT_W'(1);
      if (flush_ev && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
